// File: rtl/pc_updater.sv
// Fetch-stage program counter: holds PC and selects the next PC.
// The next PC is PC+2, a branch target, or the held value while halted.
module pc_updater #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AddrSrc,
  input  logic [15:0] InAddrImm,
  input  logic [15:0] InAddrReg,
  input  logic        branch,
  input  logic [2:0]  cond,
  input  logic        Z,
  input  logic        N,
  input  logic        V,
  input  logic        hlt,
  output logic [15:0] OutAddr,
  output logic [15:0] PCSOut
);

  logic [15:0] r_pc;
  logic [15:0] w_pc_plus2;
  logic [15:0] w_target;
  logic [15:0] w_pc_next;
  logic        w_take;

  assign w_pc_plus2 = r_pc + 16'd2;
  // The offset counts instruction words, so shift it left once to get bytes.
  assign w_target   = AddrSrc ? (w_pc_plus2 + {InAddrImm[14:0], 1'b0}) : InAddrReg;

  // The 111 code is matched before any flag is read, so unknown flags cannot leak into it.
  always_comb begin
    w_take = 1'b0;
    case (cond)
      3'b111:  w_take = 1'b1;
      3'b000:  w_take = ~Z;
      3'b001:  w_take = Z;
      3'b010:  w_take = ~Z & ~N;
      3'b011:  w_take = N;
      3'b100:  w_take = Z | (~Z & ~N);
      3'b101:  w_take = N | Z;
      3'b110:  w_take = V;
      default: w_take = 1'b0;
    endcase
  end

  always_comb begin
    w_pc_next = w_pc_plus2;
    if (hlt) begin
      w_pc_next = r_pc;
    end else if (branch && w_take) begin
      w_pc_next = w_target;
    end else begin
      w_pc_next = w_pc_plus2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign OutAddr = r_pc;
  assign PCSOut  = w_pc_plus2;

endmodule

// File: tb/tb_pc_updater.sv
// Testbench for pc_updater: directed walk through the branch and halt cases, then random cycles.
// A reference model computes every expected PC.
module tb_pc_updater;

  logic        clk = 1'b0;
  logic        rst;
  logic        AddrSrc;
  logic [15:0] InAddrImm;
  logic [15:0] InAddrReg;
  logic        branch;
  logic [2:0]  cond;
  logic        Z, N, V;
  logic        hlt;
  logic [15:0] OutAddr;
  logic [15:0] PCSOut;

  int total = 0;
  int bad   = 0;
  logic [15:0] m_pc;

  pc_updater #(.RESET_VECTOR(16'h0000)) dut (
    .clk(clk), .rst(rst), .AddrSrc(AddrSrc), .InAddrImm(InAddrImm),
    .InAddrReg(InAddrReg), .branch(branch), .cond(cond), .Z(Z), .N(N), .V(V),
    .hlt(hlt), .OutAddr(OutAddr), .PCSOut(PCSOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_take(input logic [2:0] c, input logic z, input logic n, input logic v);
    if (c == 3'd7) return 1'b1;
    case (c)
      3'd0: return z == 1'b0;
      3'd1: return z == 1'b1;
      3'd2: return (z == 1'b0) && (n == 1'b0);
      3'd3: return n == 1'b1;
      3'd4: return (z == 1'b1) || ((z == 1'b0) && (n == 1'b0));
      3'd5: return (n == 1'b1) || (z == 1'b1);
      3'd6: return v == 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one instruction's inputs, step one clock edge, then compare against the model.
  task automatic cyc(input logic b, input logic [2:0] c, input logic z, input logic n,
                     input logic v, input logic src, input logic [15:0] imm,
                     input logic [15:0] rg, input logic h, input string tag);
    int e;
    branch = b; cond = c; Z = z; N = n; V = v; AddrSrc = src;
    InAddrImm = imm; InAddrReg = rg; hlt = h;
    if (h)
      e = int'(m_pc);
    else if (b && model_take(c, z, n, v))
      e = src ? ((int'(m_pc) + 2 + 2 * int'($signed(imm))) & 32'hFFFF) : int'(rg);
    else
      e = (int'(m_pc) + 2) & 32'hFFFF;
    @(posedge clk);
    #1;
    m_pc = e[15:0];
    chk(tag, OutAddr, m_pc);
    chk({tag, "_pcs"}, PCSOut, e[15:0] + 16'd2);
  endtask

  initial begin
    rst = 1'b0; AddrSrc = 1'b0; InAddrImm = 16'h0000; InAddrReg = 16'h0000;
    branch = 1'b0; cond = 3'd0; Z = 1'b0; N = 1'b0; V = 1'b0; hlt = 1'b0;
    m_pc = 16'h0000;
    #2;
    chk("rst_pc", OutAddr, 16'h0000);
    chk("rst_pcs", PCSOut, 16'h0002);
    @(negedge clk);
    rst = 1'b1;

    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "free1");
    cyc(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'd10, 1'b0, "ne_nt");
    cyc(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'd10, 1'b0, "ne_t");
    cyc(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'd20, 1'b0, "eq_nt");
    cyc(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'd20, 1'b0, "eq_t");
    cyc(1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'd30, 1'b0, "gt_nt");
    cyc(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'd30, 1'b0, "gt_t");
    cyc(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'd40, 1'b0, "lt_nt");
    cyc(1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'd40, 1'b0, "lt_t");
    cyc(1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'd50, 1'b0, "ge_nt");
    cyc(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'd50, 1'b0, "ge_t0");
    cyc(1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'd60, 1'b0, "ge_t1");
    cyc(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'd70, 1'b0, "le_nt");
    cyc(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'd70, 1'b0, "le_t0");
    cyc(1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'd80, 1'b0, "le_t1");
    cyc(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'd100, 1'b0, "ov_nt");
    cyc(1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'd100, 1'b0, "ov_t");
    cyc(1'b1, 3'd7, 1'bx, 1'bx, 1'bx, 1'b0, 16'h0, 16'd100, 1'b0, "uncond_x");
    cyc(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'd200, 1'b1, "hlt_br");
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'd0, 1'b1, "hlt");
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'd0, 1'b0, "resume");
    cyc(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0010, 1'b0, "to_10");
    cyc(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 16'h0, 1'b0, "imm_neg");
    cyc(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0, 1'b0, "imm_pos");
    cyc(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'hFFFE, 1'b0, "to_fffe");
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "wrap");
    cyc(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0040, 1'b0, "to_40");

    // Reset dropped between edges must clear the PC without waiting for a clock.
    #2;
    rst = 1'b0;
    #1;
    m_pc = 16'h0000;
    chk("async_rst", OutAddr, m_pc);
    chk("async_rst_pcs", PCSOut, 16'h0002);
    @(posedge clk);
    #1;
    chk("rst_hold", OutAddr, m_pc);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "post_rst");

    for (int i = 0; i < 400; i++) begin
      logic [15:0] rimm;
      rimm = 16'($urandom);
      cyc(1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), rimm, 16'($urandom) & 16'hFFFE,
          ($urandom_range(0, 7) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
